// File: rtl/avs_mem_responder_pkg.sv
// rtl/avs_mem_responder_pkg.sv - shared state encoding and word geometry for the Avalon-MM memory responder
package avs_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_bytewise_ram.sv
// rtl/mem_bytewise_ram.sv - single-port synchronous RAM with per-byte write enables and registered read
module mem_bytewise_ram
  import avs_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                            clk,
  input  logic                            rd_en_i,
  input  logic [be_width(DATA_WIDTH)-1:0] wr_be_i,
  input  logic [DEPTH_LOG2-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  output logic [DATA_WIDTH-1:0]           rdata_o
);

  localparam int NB = be_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  // No reset here so the array and its output register map onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_be_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (rd_en_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/avs_mem_responder.sv
// rtl/avs_mem_responder.sv - Avalon-MM slave memory with wait states, legality checks and transfer counters
module avs_mem_responder
  import avs_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic                            AVS_Clk,
  input  logic                            AVS_Reset,
  input  logic [ADDR_WIDTH-1:0]           AVS_s_address,
  input  logic                            AVS_s_read,
  input  logic                            AVS_s_write,
  input  logic [DATA_WIDTH-1:0]           AVS_s_writedata,
  input  logic [be_width(DATA_WIDTH)-1:0] AVS_s_byteenable,
  output logic [DATA_WIDTH-1:0]           AVS_s_readdata,
  output logic                            AVS_s_waitrequest,
  output logic                            MEM_Err,
  input  logic                            MEM_Err_Clr,
  output logic [31:0]                     MEM_Rd_Count,
  output logic [31:0]                     MEM_Wr_Count
);

  localparam int         NB  = be_width(DATA_WIDTH);
  localparam int         OFS = $clog2(BYTES_PER_WORD);
  localparam logic [3:0] WS  = 4'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    is_wr_q, is_wr_d;
  logic                    oor_q, oor_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             rd_cnt_q, rd_cnt_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;

  logic                    req;
  logic                    addr_oor;
  logic                    addr_mis;
  logic [DEPTH_LOG2-1:0]   addr_idx;
  logic                    err_set;
  logic                    ram_rd;
  logic [NB-1:0]           ram_be;
  logic [DEPTH_LOG2-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [DATA_WIDTH-1:0]   ack_rdata;

  assign req      = AVS_s_read | AVS_s_write;
  assign addr_idx = AVS_s_address[DEPTH_LOG2+OFS-1:OFS];
  assign addr_oor = |AVS_s_address[ADDR_WIDTH-1:DEPTH_LOG2+OFS];
  assign addr_mis = |AVS_s_address[OFS-1:0];

  assign AVS_s_waitrequest = req & (state_q != ST_ACK);

  // With zero wait states the read is launched from IDLE, before the index is captured.
  assign ram_addr  = (state_q == ST_IDLE) ? addr_idx : idx_q;
  assign ack_rdata = oor_q ? '0 : ram_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    oor_d    = oor_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_set  = 1'b0;
    ram_rd   = 1'b0;
    ram_be   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          is_wr_d = AVS_s_write;
          oor_d   = addr_oor;
          idx_d   = addr_idx;
          wdata_d = AVS_s_writedata;
          be_d    = AVS_s_byteenable;
          err_set = (AVS_s_read & AVS_s_write) | addr_oor | addr_mis;
          if (WS == 4'd0) begin
            ram_rd  = ~AVS_s_write;
            state_d = ST_ACK;
          end else begin
            cnt_d   = WS;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q <= 4'd1) begin
          ram_rd  = ~is_wr_q;
          cnt_d   = '0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (is_wr_q) begin
          ram_be   = oor_q ? '0 : be_q;
          wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
          rdata_d  = ack_rdata;
          rd_cnt_d = rd_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = MEM_Err_Clr ? 1'b0 : (err_q | err_set);
  end

  always_ff @(posedge AVS_Clk or negedge AVS_Reset) begin
    if (!AVS_Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      oor_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      oor_q    <= oor_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign AVS_s_readdata = (state_q == ST_ACK && !is_wr_q) ? ack_rdata : rdata_q;
  assign MEM_Err        = err_q;
  assign MEM_Rd_Count   = rd_cnt_q;
  assign MEM_Wr_Count   = wr_cnt_q;

  mem_bytewise_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (AVS_Clk),
    .rd_en_i (ram_rd),
    .wr_be_i (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_avs_mem_responder.sv
// tb/tb_avs_mem_responder.sv - self-checking bench for avs_mem_responder (2 and 0 wait states)
module tb_avs_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0][31:0] addr;
  logic [1:0]       rd;
  logic [1:0]       wr;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] rdata;
  logic [1:0]       wreq;
  logic [1:0]       err;
  logic [1:0]       clr;
  logic [1:0][31:0] rcnt;
  logic [1:0][31:0] wcnt;

  int total = 0;
  int bad   = 0;

  avs_mem_responder #(.WAIT_STATES(2)) dut_ws2 (
    .AVS_Clk(clk), .AVS_Reset(rst_n[0]), .AVS_s_address(addr[0]),
    .AVS_s_read(rd[0]), .AVS_s_write(wr[0]), .AVS_s_writedata(wdata[0]),
    .AVS_s_byteenable(be[0]), .AVS_s_readdata(rdata[0]), .AVS_s_waitrequest(wreq[0]),
    .MEM_Err(err[0]), .MEM_Err_Clr(clr[0]), .MEM_Rd_Count(rcnt[0]), .MEM_Wr_Count(wcnt[0])
  );

  avs_mem_responder #(.WAIT_STATES(0)) dut_ws0 (
    .AVS_Clk(clk), .AVS_Reset(rst_n[1]), .AVS_s_address(addr[1]),
    .AVS_s_read(rd[1]), .AVS_s_write(wr[1]), .AVS_s_writedata(wdata[1]),
    .AVS_s_byteenable(be[1]), .AVS_s_readdata(rdata[1]), .AVS_s_waitrequest(wreq[1]),
    .MEM_Err(err[1]), .MEM_Err_Clr(clr[1]), .MEM_Rd_Count(rcnt[1]), .MEM_Wr_Count(wcnt[1])
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic        c;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  logic [31:0] mdl [int];
  logic        m_err;
  int          m_rc, m_wc;

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b, input logic c,
                              input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.b = b; v.c = c;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one transfer from a negedge; returns read data seen while waitrequest is low
  // and the number of sampled waitrequest-high cycles. Clear is held only for the first cycle.
  task automatic xfer(input int u, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input logic c,
                      output logic [31:0] got, output int waits);
    int n = 0;
    addr[u] = a; rd[u] = r; wr[u] = w; wdata[u] = d; be[u] = b; clr[u] = c;
    #1;
    while (wreq[u] === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
      clr[u] = 1'b0;
      #1;
    end
    if (n >= 64) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout: got waitrequest stuck high expected release");
    end
    got   = rdata[u];
    waits = n;
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0; clr[u] = 1'b0;
  endtask

  // Reference behaviour for one completed transfer on the zero-wait-state instance.
  task automatic model_xfer(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b, input logic c,
                            output logic [31:0] exp_rd);
    logic        oor;
    logic        bad_ev;
    int          idx;
    logic [31:0] word;
    oor    = (a >> 14) != 0;
    idx    = int'(a[13:2]);
    bad_ev = (r & w) | (a[1:0] != 2'b00) | oor;
    exp_rd = 32'h0;
    if (w) begin
      if (!oor) begin
        word = mdl.exists(idx) ? mdl[idx] : 32'h0;
        for (int l = 0; l < 4; l++) if (b[l]) word[l*8 +: 8] = d[l*8 +: 8];
        mdl[idx] = word;
      end
      m_wc++;
    end else begin
      exp_rd = oor ? 32'h0 : mdl[idx];
      m_rc++;
    end
    m_err = c ? 1'b0 : (m_err | bad_ev);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int          nw;
    logic        r, w, c;
    logic [31:0] a, d, er;
    logic [3:0]  b;
    int          sel;

    tbl[0]  = mk(0, 1, 32'h10,       32'h0000ABCD, 4'hF, 0, 0, 32'h0,        0);
    tbl[1]  = mk(1, 0, 32'h10,       32'h0,        4'hF, 0, 1, 32'h0000ABCD, 0);
    tbl[2]  = mk(0, 1, 32'h20,       32'hFFFFFFFF, 4'hF, 0, 0, 32'h0,        0);
    tbl[3]  = mk(0, 1, 32'h20,       32'h12345678, 4'h5, 0, 0, 32'h0,        0);
    tbl[4]  = mk(1, 0, 32'h20,       32'h0,        4'hF, 0, 1, 32'hFF34FF78, 0);
    tbl[5]  = mk(1, 0, 32'h00010000, 32'h0,        4'hF, 0, 1, 32'h0,        1);
    tbl[6]  = mk(1, 0, 32'h20,       32'h0,        4'hF, 1, 1, 32'hFF34FF78, 0);
    tbl[7]  = mk(1, 1, 32'h04,       32'h00000055, 4'hF, 0, 0, 32'h0,        1);
    tbl[8]  = mk(1, 0, 32'h04,       32'h0,        4'hF, 1, 1, 32'h00000055, 0);
    tbl[9]  = mk(1, 1, 32'h04,       32'h00000077, 4'hF, 1, 0, 32'h0,        0);
    tbl[10] = mk(1, 0, 32'h04,       32'h0,        4'hF, 0, 1, 32'h00000077, 0);
    tbl[11] = mk(0, 1, 32'h13,       32'hCAFEF00D, 4'hF, 0, 0, 32'h0,        1);
    tbl[12] = mk(1, 0, 32'h10,       32'h0,        4'hF, 1, 1, 32'hCAFEF00D, 0);
    tbl[13] = mk(0, 1, 32'h00004010, 32'h00000001, 4'hF, 0, 0, 32'h0,        1);
    tbl[14] = mk(1, 0, 32'h10,       32'h0,        4'hF, 1, 1, 32'hCAFEF00D, 0);
    tbl[15] = mk(0, 1, 32'h10,       32'h0,        4'h0, 0, 0, 32'h0,        0);
    tbl[16] = mk(1, 0, 32'h10,       32'h0,        4'hF, 0, 1, 32'hCAFEF00D, 0);

    rst_n = 2'b00; addr = '0; rd = '0; wr = '0; wdata = '0; be = '0; clr = '0;
    repeat (2) @(negedge clk);
    rst_n = 2'b11;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset_rdata%0d", u), rdata[u], 32'h0);
      chk($sformatf("reset_err%0d", u),   {31'd0, err[u]}, 32'd0);
      chk($sformatf("reset_rcnt%0d", u),  rcnt[u], 32'd0);
      chk($sformatf("reset_wcnt%0d", u),  wcnt[u], 32'd0);
      chk($sformatf("reset_wreq%0d", u),  {31'd0, wreq[u]}, 32'd0);
    end
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      xfer(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].c, got, nw);
      chk($sformatf("v%0d_waits", i), 32'(nw), 32'd3);
      if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), got, tbl[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, err[0]}, {31'd0, tbl[i].exp_err});
    end
    chk("tbl_rcnt", rcnt[0], 32'd9);
    chk("tbl_wcnt", wcnt[0], 32'd8);

    addr[0] = 32'h10; rd[0] = 1'b1;
    @(negedge clk);
    rd[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("withdraw_wreq", {31'd0, wreq[0]}, 32'd0);
    chk("withdraw_err",  {31'd0, err[0]},  32'd1);
    chk("withdraw_rcnt", rcnt[0], 32'd9);
    chk("withdraw_wcnt", wcnt[0], 32'd8);
    @(negedge clk);
    xfer(0, 1, 0, 32'h10, 32'h0, 4'hF, 1, got, nw);
    chk("after_withdraw_waits", 32'(nw), 32'd3);
    chk("after_withdraw_rdata", got, 32'hCAFEF00D);
    chk("after_withdraw_err",   {31'd0, err[0]}, 32'd0);

    xfer(0, 0, 1, 32'h08, 32'h11112222, 4'hF, 0, got, nw);
    addr[0] = 32'h08; wr[0] = 1'b1; wdata[0] = 32'h0000DEAD; be[0] = 4'hF;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1; wr[0] = 1'b0;
    #1;
    chk("midrst_rcnt",  rcnt[0], 32'd0);
    chk("midrst_wcnt",  wcnt[0], 32'd0);
    chk("midrst_err",   {31'd0, err[0]}, 32'd0);
    chk("midrst_rdata", rdata[0], 32'h0);
    @(negedge clk);
    xfer(0, 1, 0, 32'h08, 32'h0, 4'hF, 0, got, nw);
    chk("midrst_idle_waits", 32'(nw), 32'd3);
    chk("midrst_keep",       got, 32'h11112222);
    chk("midrst_rcnt_after", rcnt[0], 32'd1);

    m_err = 1'b0; m_rc = 0; m_wc = 0;
    for (int i = 0; i < 8; i++) begin
      d = 32'(-32768 + i * 4097);
      model_xfer(0, 1, 32'h100 + 32'(i * 4), d, 4'hF, 0, er);
      xfer(1, 0, 1, 32'h100 + 32'(i * 4), d, 4'hF, 0, got, nw);
      chk($sformatf("stream_w%0d_waits", i), 32'(nw), 32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      model_xfer(1, 0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, 0, er);
      xfer(1, 1, 0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, 0, got, nw);
      chk($sformatf("stream_r%0d_waits", i), 32'(nw), 32'd1);
      chk($sformatf("stream_r%0d_data", i), got, er);
    end
    chk("stream_wcnt", wcnt[1], 32'd8);
    chk("stream_rcnt", rcnt[1], 32'd8);

    for (int k = 0; k < 16; k++) begin
      d = $urandom;
      model_xfer(0, 1, 32'h200 + 32'(k * 4), d, 4'hF, 0, er);
      xfer(1, 0, 1, 32'h200 + 32'(k * 4), d, 4'hF, 0, got, nw);
    end
    for (int i = 0; i < 300; i++) begin
      a   = 32'h200 + 32'($urandom_range(0, 15) * 4);
      d   = $urandom;
      b   = 4'($urandom_range(0, 15));
      r   = 1'($urandom_range(0, 1));
      w   = ~r;
      c   = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      if (sel == 1) a = a | (32'h1 << $urandom_range(14, 31));
      if (sel == 2) begin r = 1'b1; w = 1'b1; end
      model_xfer(r, w, a, d, b, c, er);
      xfer(1, r, w, a, d, b, c, got, nw);
      chk($sformatf("rnd%0d_waits", i), 32'(nw), 32'd1);
      if (!w) chk($sformatf("rnd%0d_rdata", i), got, er);
      chk($sformatf("rnd%0d_err", i), {31'd0, err[1]}, {31'd0, m_err});
    end
    chk("rnd_rcnt", rcnt[1], 32'(m_rc));
    chk("rnd_wcnt", wcnt[1], 32'(m_wc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
